axi4_lite_regbank_slave: RTL and testbench

AXI4-Lite responder that terminates master transactions into a bank of NUM_REGS 32-bit control/status registers. It sits on the slave side of the AXI4-Lite channel pair driven by axi4_lite_master. It exposes every register flat to the surrounding logic, plus a per-register write-pulse vector. It supports independent AW/W arrival, byte strobes and SLVERR on out-of-range addresses.

---
 rtl/axi4_lite_regbank_slave.sv | 218 +++++++++++++++++++++
 tb/tb_axi4_lite_regbank_slave.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_lite_regbank_slave.sv
// AXI4-Lite slave that terminates transactions into NUM_REGS 32-bit registers,
// exposed flat on reg_out with a per-register write pulse. Define AXIL_REGBANK_WSTRB_EN to honour byte strobes.
module axi4_lite_regbank_slave #(
    parameter int                 DATA_WIDTH = 32,
    parameter int                 ADDRESS    = 32,
    parameter int                 NUM_REGS   = 8,
    parameter logic [ADDRESS-1:0] BASE_ADDR  = '0
) (
    input  logic                           ACLK,
    input  logic                           ARESET,
    input  logic [ADDRESS-1:0]             S_AWADDR,
    input  logic                           S_AWVALID,
    output logic                           S_AWREADY,
    input  logic [DATA_WIDTH-1:0]          S_WDATA,
    input  logic [3:0]                     S_WSTRB,
    input  logic                           S_WVALID,
    output logic                           S_WREADY,
    output logic [1:0]                     S_BRESP,
    output logic                           S_BVALID,
    input  logic                           S_BREADY,
    input  logic [ADDRESS-1:0]             S_ARADDR,
    input  logic                           S_ARVALID,
    output logic                           S_ARREADY,
    output logic [DATA_WIDTH-1:0]          S_RDATA,
    output logic [1:0]                     S_RRESP,
    output logic                           S_RVALID,
    input  logic                           S_RREADY,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
    output logic [NUM_REGS-1:0]            wr_pulse
);
    localparam int                 IDX_W  = $clog2(NUM_REGS);
    localparam logic [ADDRESS-1:0] SPAN   = ADDRESS'(4 * NUM_REGS);
    localparam logic [1:0]         OKAY   = 2'b00;
    localparam logic [1:0]         SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_RESP} r_state_t;

    function automatic logic addr_ok(input logic [ADDRESS-1:0] addr);
        logic [ADDRESS-1:0] offset;
        offset = addr - BASE_ADDR;
        return (addr >= BASE_ADDR) && (offset < SPAN);
    endfunction

    w_state_t                w_state_reg, w_state_next;
    logic                    aw_ready_reg, w_ready_reg;
    logic [ADDRESS-1:0]      aw_addr_reg;
    logic [DATA_WIDTH-1:0]   w_data_reg;
    logic                    bvalid_reg;
    logic [1:0]              bresp_reg;
    logic [NUM_REGS-1:0]     wr_pulse_reg;

    logic                    aw_hs, w_hs, commit, commit_ok;
    logic [ADDRESS-1:0]      commit_addr;
    logic [DATA_WIDTH-1:0]   commit_data;
    logic [IDX_W-1:0]        commit_idx;
    logic [NUM_REGS-1:0]     wr_sel;
`ifdef AXIL_REGBANK_WSTRB_EN
    logic [3:0]              w_strb_reg, commit_strb;
`else
    logic                    unused_strb;
    assign unused_strb = ^S_WSTRB;
`endif

    assign aw_hs      = S_AWVALID & aw_ready_reg;
    assign w_hs       = S_WVALID & w_ready_reg;
    assign commit_ok  = addr_ok(commit_addr);
    assign commit_idx = commit_addr[2 +: IDX_W];

    // Whichever channel arrives last supplies its value live; the earlier one comes from its latch.
    always_comb begin
        w_state_next = w_state_reg;
        commit       = 1'b0;
        commit_addr  = S_AWADDR;
        commit_data  = S_WDATA;
`ifdef AXIL_REGBANK_WSTRB_EN
        commit_strb  = S_WSTRB;
`endif
        case (w_state_reg)
            W_IDLE: begin
                if (aw_hs && w_hs) begin
                    commit       = 1'b1;
                    w_state_next = W_RESP;
                end else if (aw_hs) begin
                    w_state_next = W_HAVE_AW;
                end else if (w_hs) begin
                    w_state_next = W_HAVE_W;
                end
            end
            W_HAVE_AW: begin
                commit_addr = aw_addr_reg;
                if (w_hs) begin
                    commit       = 1'b1;
                    w_state_next = W_RESP;
                end
            end
            W_HAVE_W: begin
                commit_data = w_data_reg;
`ifdef AXIL_REGBANK_WSTRB_EN
                commit_strb = w_strb_reg;
`endif
                if (aw_hs) begin
                    commit       = 1'b1;
                    w_state_next = W_RESP;
                end
            end
            W_RESP: begin
                if (S_BREADY) w_state_next = W_IDLE;
            end
            default: w_state_next = W_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            w_state_reg  <= W_IDLE;
            aw_ready_reg <= 1'b0;
            w_ready_reg  <= 1'b0;
            aw_addr_reg  <= '0;
            w_data_reg   <= '0;
`ifdef AXIL_REGBANK_WSTRB_EN
            w_strb_reg   <= '0;
`endif
            bvalid_reg   <= 1'b0;
            bresp_reg    <= OKAY;
            wr_pulse_reg <= '0;
        end else begin
            w_state_reg  <= w_state_next;
            aw_ready_reg <= (w_state_next == W_IDLE) || (w_state_next == W_HAVE_W);
            w_ready_reg  <= (w_state_next == W_IDLE) || (w_state_next == W_HAVE_AW);
            if (aw_hs) aw_addr_reg <= S_AWADDR;
            if (w_hs) begin
                w_data_reg <= S_WDATA;
`ifdef AXIL_REGBANK_WSTRB_EN
                w_strb_reg <= S_WSTRB;
`endif
            end
            wr_pulse_reg <= wr_sel;
            if (commit) begin
                bvalid_reg <= 1'b1;
                bresp_reg  <= commit_ok ? OKAY : SLVERR;
            end else if (bvalid_reg && S_BREADY) begin
                bvalid_reg <= 1'b0;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            logic [DATA_WIDTH-1:0] value_reg, value_next;
            assign wr_sel[gi] = commit && commit_ok && (commit_idx == IDX_W'(gi));
`ifdef AXIL_REGBANK_WSTRB_EN
            for (genvar bi = 0; bi < 4; bi++) begin : g_byte
                assign value_next[8*bi +: 8] = commit_strb[bi] ? commit_data[8*bi +: 8]
                                                               : value_reg[8*bi +: 8];
            end
`else
            assign value_next = commit_data;
`endif
            always_ff @(posedge ACLK or posedge ARESET) begin
                if (ARESET)          value_reg <= '0;
                else if (wr_sel[gi]) value_reg <= value_next;
            end
            assign reg_out[gi*DATA_WIDTH +: DATA_WIDTH] = value_reg;
        end
    endgenerate

    r_state_t              r_state_reg, r_state_next;
    logic                  ar_ready_reg, rvalid_reg, ar_hs, ar_ok;
    logic [DATA_WIDTH-1:0] rdata_reg;
    logic [1:0]            rresp_reg;
    logic [IDX_W-1:0]      ar_idx;

    assign ar_hs  = S_ARVALID & ar_ready_reg;
    assign ar_ok  = addr_ok(S_ARADDR);
    assign ar_idx = S_ARADDR[2 +: IDX_W];

    always_comb begin
        r_state_next = r_state_reg;
        case (r_state_reg)
            R_IDLE:  if (ar_hs)    r_state_next = R_RESP;
            R_RESP:  if (S_RREADY) r_state_next = R_IDLE;
            default: r_state_next = R_IDLE;
        endcase
    end

    // reg_out holds pre-commit values, so a same-edge read sees the old word.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_state_reg  <= R_IDLE;
            ar_ready_reg <= 1'b0;
            rvalid_reg   <= 1'b0;
            rdata_reg    <= '0;
            rresp_reg    <= OKAY;
        end else begin
            r_state_reg  <= r_state_next;
            ar_ready_reg <= (r_state_next == R_IDLE);
            if (ar_hs) begin
                rvalid_reg <= 1'b1;
                rdata_reg  <= ar_ok ? reg_out[ar_idx*DATA_WIDTH +: DATA_WIDTH] : '0;
                rresp_reg  <= ar_ok ? OKAY : SLVERR;
            end else if (rvalid_reg && S_RREADY) begin
                rvalid_reg <= 1'b0;
            end
        end
    end

    assign S_AWREADY = aw_ready_reg;
    assign S_WREADY  = w_ready_reg;
    assign S_BVALID  = bvalid_reg;
    assign S_BRESP   = bresp_reg;
    assign S_ARREADY = ar_ready_reg;
    assign S_RVALID  = rvalid_reg;
    assign S_RDATA   = rdata_reg;
    assign S_RRESP   = rresp_reg;
    assign wr_pulse  = wr_pulse_reg;
endmodule

// File: tb/tb_axi4_lite_regbank_slave.sv
// Self-checking bench for axi4_lite_regbank_slave: directed scenarios plus randomized traffic
// against an array model of the register bank.
module tb_axi4_lite_regbank_slave;
    localparam int NR = 8;

    logic          ACLK = 1'b0;
    logic          ARESET = 1'b1;
    logic [31:0]   S_AWADDR = '0;
    logic          S_AWVALID = 1'b0;
    logic          S_AWREADY;
    logic [31:0]   S_WDATA = '0;
    logic [3:0]    S_WSTRB = '0;
    logic          S_WVALID = 1'b0;
    logic          S_WREADY;
    logic [1:0]    S_BRESP;
    logic          S_BVALID;
    logic          S_BREADY = 1'b0;
    logic [31:0]   S_ARADDR = '0;
    logic          S_ARVALID = 1'b0;
    logic          S_ARREADY;
    logic [31:0]   S_RDATA;
    logic [1:0]    S_RRESP;
    logic          S_RVALID;
    logic          S_RREADY = 1'b0;
    logic [NR*32-1:0] reg_out;
    logic [NR-1:0] wr_pulse;

    int total = 0;
    int bad   = 0;
    logic [31:0] model [NR];

    axi4_lite_regbank_slave #(.DATA_WIDTH(32), .ADDRESS(32), .NUM_REGS(NR), .BASE_ADDR(32'h0)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .S_AWADDR(S_AWADDR), .S_AWVALID(S_AWVALID), .S_AWREADY(S_AWREADY),
        .S_WDATA(S_WDATA), .S_WSTRB(S_WSTRB), .S_WVALID(S_WVALID), .S_WREADY(S_WREADY),
        .S_BRESP(S_BRESP), .S_BVALID(S_BVALID), .S_BREADY(S_BREADY),
        .S_ARADDR(S_ARADDR), .S_ARVALID(S_ARVALID), .S_ARREADY(S_ARREADY),
        .S_RDATA(S_RDATA), .S_RRESP(S_RRESP), .S_RVALID(S_RVALID), .S_RREADY(S_RREADY),
        .reg_out(reg_out), .wr_pulse(wr_pulse)
    );

    always #5 ACLK = ~ACLK;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1, "watchdog");
    end

    function automatic bit in_range(input logic [31:0] a);
        return a < 32'(4 * NR);
    endfunction

    function automatic logic [31:0] apply_write(input logic [31:0] old_v, input logic [31:0] new_v,
                                                input logic [3:0] strb);
        logic [31:0] r;
`ifdef AXIL_REGBANK_WSTRB_EN
        r = old_v;
        for (int b = 0; b < 4; b++)
            if (strb[b]) r[8*b +: 8] = new_v[8*b +: 8];
`else
        logic unused_bits;
        unused_bits = ^{old_v, strb};
        r = new_v;
`endif
        return r;
    endfunction

    function automatic logic [NR*32-1:0] model_flat();
        logic [NR*32-1:0] f;
        for (int i = 0; i < NR; i++) f[i*32 +: 32] = model[i];
        return f;
    endfunction

    // Drives one write with per-channel start delays; pulse is sampled the cycle after the commit.
    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int aw_dly, input int w_dly, output logic [1:0] resp,
                             output logic [NR-1:0] pulse, output int bwait, output bit to);
        int c;
        bit aw_done, w_done, aw_go, w_go;
        c = 0; aw_done = 0; w_done = 0; to = 0; bwait = 0; resp = 2'b11; pulse = '0;
        while (!(aw_done && w_done)) begin
            @(negedge ACLK);
            if (!aw_done && c == aw_dly) begin S_AWADDR = addr; S_AWVALID = 1'b1; end
            if (!w_done && c == w_dly) begin S_WDATA = data; S_WSTRB = strb; S_WVALID = 1'b1; end
            aw_go = S_AWVALID && S_AWREADY;
            w_go  = S_WVALID && S_WREADY;
            @(posedge ACLK); #1;
            if (aw_go) begin S_AWVALID = 1'b0; aw_done = 1; end
            if (w_go)  begin S_WVALID = 1'b0;  w_done = 1;  end
            c++;
            if (c > 40) begin to = 1; S_AWVALID = 1'b0; S_WVALID = 1'b0; return; end
        end
        @(negedge ACLK);
        pulse = wr_pulse;
        while (!S_BVALID) begin
            if (bwait >= 20) begin to = 1; return; end
            bwait++;
            @(negedge ACLK);
        end
        resp = S_BRESP;
        S_BREADY = 1'b1;
        @(posedge ACLK); #1;
        S_BREADY = 1'b0;
    endtask

    task automatic axi_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp,
                            output int rwait, output bit to);
        int c;
        c = 0; to = 0; rwait = 0; data = '0; resp = 2'b11;
        @(negedge ACLK);
        S_ARADDR = addr; S_ARVALID = 1'b1;
        while (!S_ARREADY) begin
            if (c >= 20) begin to = 1; S_ARVALID = 1'b0; return; end
            c++;
            @(negedge ACLK);
        end
        @(posedge ACLK); #1;
        S_ARVALID = 1'b0;
        @(negedge ACLK);
        while (!S_RVALID) begin
            if (rwait >= 20) begin to = 1; return; end
            rwait++;
            @(negedge ACLK);
        end
        data = S_RDATA; resp = S_RRESP;
        S_RREADY = 1'b1;
        @(posedge ACLK); #1;
        S_RREADY = 1'b0;
    endtask

    task automatic test_reset();
        ARESET = 1'b1;
        repeat (3) @(negedge ACLK);
        total++;
        if ({S_AWREADY, S_WREADY, S_ARREADY} !== 3'b000) begin
            bad++; $display("FAIL reset_ready: got %b want 000", {S_AWREADY, S_WREADY, S_ARREADY});
        end
        total++;
        if ({S_BVALID, S_BRESP, S_RVALID, S_RRESP, S_RDATA, wr_pulse} !== '0) begin
            bad++; $display("FAIL reset_outputs: got %h want 0", {S_BVALID, S_BRESP, S_RVALID, S_RRESP, S_RDATA, wr_pulse});
        end
        total++;
        if (reg_out !== '0) begin bad++; $display("FAIL reset_regs: got %h want 0", reg_out); end
        ARESET = 1'b0;
        #1;
        total++;
        if ({S_AWREADY, S_WREADY, S_ARREADY} !== 3'b000) begin
            bad++; $display("FAIL ready_before_edge: got %b want 000", {S_AWREADY, S_WREADY, S_ARREADY});
        end
        @(negedge ACLK);
        total++;
        if ({S_AWREADY, S_WREADY, S_ARREADY} !== 3'b111) begin
            bad++; $display("FAIL ready_after_release: got %b want 111", {S_AWREADY, S_WREADY, S_ARREADY});
        end
        for (int i = 0; i < NR; i++) model[i] = '0;
        $display("reset: readys=%b", {S_AWREADY, S_WREADY, S_ARREADY});
    endtask

    task automatic test_same_cycle();
        logic [1:0] resp; logic [NR-1:0] pulse; int wt; bit to; logic [31:0] rd;
        axi_write(32'h08, 32'hDEADBEEF, 4'hF, 0, 0, resp, pulse, wt, to);
        model[2] = apply_write(model[2], 32'hDEADBEEF, 4'hF);
        total++;
        if ({to, resp, wt[3:0], pulse} !== {1'b0, 2'b00, 4'd0, 8'h04}) begin
            bad++; $display("FAIL same_cycle_write: got to=%0d resp=%b wait=%0d pulse=%h want 0 00 0 04", to, resp, wt, pulse);
        end
        axi_read(32'h08, rd, resp, wt, to);
        total++;
        if ({to, rd, resp, wt[3:0]} !== {1'b0, 32'hDEADBEEF, 2'b00, 4'd0}) begin
            bad++; $display("FAIL same_cycle_read: got to=%0d data=%h resp=%b wait=%0d want 0 deadbeef 00 0", to, rd, resp, wt);
        end
        $display("same_cycle: write 0x08 <= deadbeef, read %h resp %b", rd, resp);
    endtask

    task automatic test_w_before_aw();
        @(negedge ACLK);
        S_WDATA = 32'h12345678; S_WSTRB = 4'hF; S_WVALID = 1'b1;
        total++;
        if (S_WREADY !== 1'b1) begin bad++; $display("FAIL w_first_wready: got %b want 1", S_WREADY); end
        @(posedge ACLK); #1;
        S_WVALID = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge ACLK);
            total++;
            if ({S_AWREADY, S_WREADY, S_BVALID, wr_pulse} !== {3'b100, 8'h00}) begin
                bad++; $display("FAIL w_first_wait: got aw=%b w=%b b=%b pulse=%h want 1 0 0 00", S_AWREADY, S_WREADY, S_BVALID, wr_pulse);
            end
        end
        S_AWADDR = 32'h04; S_AWVALID = 1'b1;
        @(posedge ACLK); #1;
        S_AWVALID = 1'b0;
        model[1] = apply_write(model[1], 32'h12345678, 4'hF);
        @(negedge ACLK);
        total++;
        if ({wr_pulse, S_BVALID, S_BRESP, reg_out[63:32]} !== {8'h02, 1'b1, 2'b00, 32'h12345678}) begin
            bad++; $display("FAIL w_first_commit: got pulse=%h b=%b resp=%b reg1=%h want 02 1 00 12345678", wr_pulse, S_BVALID, S_BRESP, reg_out[63:32]);
        end
        @(negedge ACLK);
        total++;
        if (wr_pulse !== 8'h00) begin bad++; $display("FAIL w_first_pulse_once: got %h want 00", wr_pulse); end
        S_BREADY = 1'b1;
        @(posedge ACLK); #1;
        S_BREADY = 1'b0;
        $display("w_before_aw: reg1=%h", reg_out[63:32]);
    endtask

    task automatic test_out_of_range();
        logic [1:0] resp; logic [NR-1:0] pulse; int wt; bit to; logic [31:0] rd;
        axi_write(32'h40, $urandom, 4'hF, 0, 0, resp, pulse, wt, to);
        total++;
        if ({to, resp, pulse} !== {1'b0, 2'b10, 8'h00}) begin
            bad++; $display("FAIL oor_write: got to=%0d resp=%b pulse=%h want 0 10 00", to, resp, pulse);
        end
        total++;
        if (reg_out !== model_flat()) begin bad++; $display("FAIL oor_regs: got %h want %h", reg_out, model_flat()); end
        axi_read(32'h40, rd, resp, wt, to);
        total++;
        if ({to, rd, resp} !== {1'b0, 32'h0, 2'b10}) begin
            bad++; $display("FAIL oor_read: got to=%0d data=%h resp=%b want 0 00000000 10", to, rd, resp);
        end
        $display("out_of_range: bresp=10 rdata=%h rresp=%b", rd, resp);
    endtask

    task automatic test_strobes();
        logic [1:0] resp; logic [NR-1:0] pulse; int wt; bit to; logic [31:0] exp_v;
`ifdef AXIL_REGBANK_WSTRB_EN
        exp_v = 32'hAA22CC44;
`else
        exp_v = 32'h11223344;
`endif
        axi_write(32'h00, 32'hAABBCCDD, 4'hF, 0, 0, resp, pulse, wt, to);
        axi_write(32'h00, 32'h11223344, 4'b0101, 1, 0, resp, pulse, wt, to);
        model[0] = exp_v;
        total++;
        if ({to, resp, pulse, reg_out[31:0]} !== {1'b0, 2'b00, 8'h01, exp_v}) begin
            bad++; $display("FAIL strobe_merge: got to=%0d resp=%b pulse=%h reg0=%h want 0 00 01 %h", to, resp, pulse, reg_out[31:0], exp_v);
        end
        axi_write(32'h00, 32'h55555555, 4'b0000, 0, 2, resp, pulse, wt, to);
        model[0] = apply_write(model[0], 32'h55555555, 4'b0000);
        total++;
        if ({pulse, reg_out[31:0]} !== {8'h01, model[0]}) begin
            bad++; $display("FAIL strobe_zero: got pulse=%h reg0=%h want 01 %h", pulse, reg_out[31:0], model[0]);
        end
        $display("strobes: reg0=%h", reg_out[31:0]);
    endtask

    task automatic test_backpressure();
        logic [31:0] d;
        d = $urandom;
        @(negedge ACLK);
        S_AWADDR = 32'h14; S_AWVALID = 1'b1; S_WDATA = d; S_WSTRB = 4'hF; S_WVALID = 1'b1;
        @(posedge ACLK); #1;
        S_AWVALID = 1'b0; S_WVALID = 1'b0;
        model[5] = apply_write(model[5], d, 4'hF);
        for (int i = 0; i < 5; i++) begin
            @(negedge ACLK);
            total++;
            if ({S_BVALID, S_BRESP, S_AWREADY, S_WREADY} !== 5'b10000) begin
                bad++; $display("FAIL b_hold: cycle %0d got b=%b resp=%b aw=%b w=%b want 1 00 0 0", i, S_BVALID, S_BRESP, S_AWREADY, S_WREADY);
            end
        end
        S_BREADY = 1'b1;
        @(posedge ACLK); #1;
        S_BREADY = 1'b0;
        @(negedge ACLK);
        total++;
        if ({S_BVALID, S_AWREADY, S_WREADY} !== 3'b011) begin
            bad++; $display("FAIL b_release: got b=%b aw=%b w=%b want 0 1 1", S_BVALID, S_AWREADY, S_WREADY);
        end
        S_ARADDR = 32'h14; S_ARVALID = 1'b1;
        @(posedge ACLK); #1;
        S_ARVALID = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge ACLK);
            total++;
            if ({S_RVALID, S_RDATA, S_RRESP, S_ARREADY} !== {1'b1, model[5], 2'b00, 1'b0}) begin
                bad++; $display("FAIL r_hold: cycle %0d got v=%b data=%h resp=%b ar=%b want 1 %h 00 0", i, S_RVALID, S_RDATA, S_RRESP, S_ARREADY, model[5]);
            end
        end
        S_RREADY = 1'b1;
        @(posedge ACLK); #1;
        S_RREADY = 1'b0;
        @(negedge ACLK);
        total++;
        if ({S_RVALID, S_ARREADY} !== 2'b01) begin
            bad++; $display("FAIL r_release: got v=%b ar=%b want 0 1", S_RVALID, S_ARREADY);
        end
        $display("backpressure: reg5=%h", model[5]);
    endtask

    task automatic test_back_to_back();
        logic [31:0] old_v, new_v;
        old_v = model[3];
        new_v = $urandom;
        @(negedge ACLK);
        S_AWADDR = 32'h0C; S_AWVALID = 1'b1; S_WDATA = new_v; S_WSTRB = 4'hF; S_WVALID = 1'b1;
        S_ARADDR = 32'h0C; S_ARVALID = 1'b1;
        @(posedge ACLK); #1;
        S_AWVALID = 1'b0; S_WVALID = 1'b0; S_ARVALID = 1'b0;
        model[3] = apply_write(old_v, new_v, 4'hF);
        @(negedge ACLK);
        total++;
        if ({S_RVALID, S_RDATA, S_BVALID, reg_out[127:96]} !== {1'b1, old_v, 1'b1, model[3]}) begin
            bad++; $display("FAIL same_edge_rw: got rv=%b rdata=%h bv=%b reg3=%h want 1 %h 1 %h", S_RVALID, S_RDATA, S_BVALID, reg_out[127:96], old_v, model[3]);
        end
        S_BREADY = 1'b1; S_RREADY = 1'b1;
        @(posedge ACLK); #1;
        S_BREADY = 1'b0; S_RREADY = 1'b0;
        @(negedge ACLK);
        total++;
        if ({S_AWREADY, S_WREADY, S_ARREADY, S_BVALID, S_RVALID} !== 5'b11100) begin
            bad++; $display("FAIL same_edge_idle: got %b want 11100", {S_AWREADY, S_WREADY, S_ARREADY, S_BVALID, S_RVALID});
        end
        $display("back_to_back: read old %h, reg3 now %h", old_v, reg_out[127:96]);
    endtask

    task automatic test_random(input int n);
        logic [1:0] resp; logic [NR-1:0] pulse, exp_pulse; int wt; bit to;
        logic [31:0] addr, data, rd; logic [3:0] strb; int idx;
        for (int k = 0; k < n; k++) begin
            addr = ($urandom_range(0, 11) << 2) | $urandom_range(0, 3);
            idx  = int'(addr >> 2);
            if ($urandom_range(0, 1) == 0) begin
                data = $urandom;
                strb = 4'($urandom_range(0, 15));
                axi_write(addr, data, strb, $urandom_range(0, 3), $urandom_range(0, 3), resp, pulse, wt, to);
                exp_pulse = '0;
                if (in_range(addr)) begin
                    model[idx] = apply_write(model[idx], data, strb);
                    exp_pulse[idx] = 1'b1;
                end
                total++;
                if ({to, resp, pulse} !== {1'b0, in_range(addr) ? 2'b00 : 2'b10, exp_pulse}) begin
                    bad++; $display("FAIL rand_write: addr=%h got to=%0d resp=%b pulse=%h want 0 %b %h", addr, to, resp, pulse, in_range(addr) ? 2'b00 : 2'b10, exp_pulse);
                end
                total++;
                if (reg_out !== model_flat()) begin
                    bad++; $display("FAIL rand_regs: addr=%h got %h want %h", addr, reg_out, model_flat());
                end
                $display("rand write addr=%h data=%h strb=%h resp=%b", addr, data, strb, resp);
            end else begin
                axi_read(addr, rd, resp, wt, to);
                total++;
                if ({to, rd, resp} !== {1'b0, in_range(addr) ? model[idx % NR] : 32'h0, in_range(addr) ? 2'b00 : 2'b10}) begin
                    bad++; $display("FAIL rand_read: addr=%h got to=%0d data=%h resp=%b want %h %b", addr, to, rd, resp, in_range(addr) ? model[idx % NR] : 32'h0, in_range(addr) ? 2'b00 : 2'b10);
                end
                $display("rand read addr=%h data=%h resp=%b", addr, rd, resp);
            end
        end
    endtask

    task automatic test_reset_mid();
        @(negedge ACLK);
        S_AWADDR = 32'h0C; S_AWVALID = 1'b1;
        @(posedge ACLK); #1;
        S_AWVALID = 1'b0;
        @(negedge ACLK);
        total++;
        if ({S_AWREADY, S_WREADY, reg_out} !== {2'b01, model_flat()}) begin
            bad++; $display("FAIL mid_have_aw: got aw=%b w=%b want 0 1 (regs %h)", S_AWREADY, S_WREADY, reg_out);
        end
        ARESET = 1'b1;
        #1;
        total++;
        if ({S_AWREADY, S_WREADY, S_ARREADY, S_BVALID, S_BRESP, S_RVALID, S_RRESP, S_RDATA, wr_pulse, reg_out} !== '0) begin
            bad++; $display("FAIL mid_reset_clear: got ready=%b bv=%b rv=%b regs=%h want all 0", {S_AWREADY, S_WREADY, S_ARREADY}, S_BVALID, S_RVALID, reg_out);
        end
        for (int i = 0; i < NR; i++) model[i] = '0;
        @(negedge ACLK);
        ARESET = 1'b0;
        #1;
        total++;
        if ({S_AWREADY, S_WREADY, S_ARREADY} !== 3'b000) begin
            bad++; $display("FAIL mid_ready_before_edge: got %b want 000", {S_AWREADY, S_WREADY, S_ARREADY});
        end
        @(negedge ACLK);
        total++;
        if ({S_AWREADY, S_WREADY, S_ARREADY} !== 3'b111) begin
            bad++; $display("FAIL mid_ready_after: got %b want 111", {S_AWREADY, S_WREADY, S_ARREADY});
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge ACLK);
            total++;
            if (S_BVALID !== 1'b0) begin bad++; $display("FAIL mid_no_bvalid: cycle %0d got %b want 0", i, S_BVALID); end
        end
        $display("reset_mid: regs cleared, no response after release");
    endtask

    initial begin
        test_reset();
        test_same_cycle();
        test_w_before_aw();
        test_out_of_range();
        test_strobes();
        test_backpressure();
        test_back_to_back();
        test_random(40);
        test_reset_mid();
        test_random(12);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
